mode2_sched: RTL and testbench
==============================

# mode2_sched

Sequencer and arbiter for the mode-2 arithmetic, out_4x = (a² − b²)² on 3-bit operands. Two requesters share one time-multiplexed 7-bit squarer, so the block replaces three parallel squarers with a single unit plus a small FSM. It sits between the mode-select front end and the result collector. Each requester uses a valid/ready handshake, and the result leaves on a single output port tagged with the requester id.

## Interface
- Parameters: none; widths are fixed (3-bit operands, 12-bit result).
- clk  in  1  single system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid0  in  1  requester 0 holds a valid operand pair
- in_a0, in_b0  in  3 each  requester 0 operands a, b (unsigned)
- in_ready0  out  1  requester 0 pair accepted on this edge when in_valid0 is also high
- in_valid1, in_a1, in_b1, in_ready1  same as above, requester 1
- out_valid  out  1  result register holds an unread result
- out_data  out  12  (a² − b²)², unsigned
- out_id  out  1  requester id (0/1) of out_data
- out_ready  in  1  consumer takes the result on this edge when out_valid is also high
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE → SQ_A → SQ_B → SQ_D → DONE → IDLE.
- IDLE, grant selection:
  - Grant is combinational from the valids and last_grant.
  - If only one valid is high, that requester wins.
  - If both are high, the requester ≠ last_grant wins (round-robin).
  - in_readyK = (state == IDLE) && grant == K. At most one ready is high at a time.
- Handshake edge: captures the granted a, b and the id, updates last_grant, and moves to SQ_A.
- SQ_A: squarer input = {4'b0, a}. Register a2 (6 bits) and move to SQ_B.
- SQ_B: squarer input = {4'b0, b}. Register b2.
  - diff = {1'b0,a2} − {1'b0,b2}, 7-bit two's complement.
  - Register |diff|, range 0..49. Move to SQ_D.
- SQ_D: squarer input = |diff|. The 14-bit product is truncated to [11:0]; truncation is lossless because max 49² = 2401.
  - Load out_data and out_id, set out_valid, move to DONE.
- DONE: out_data and out_id are held stable.
  - On an edge with out_valid && out_ready: clear out_valid and return to IDLE.
- No new request is accepted outside IDLE. Requesters must hold valid and operands until their ready is seen.
- Reset values: state IDLE, out_valid 0, out_data 0, out_id 0, busy 0, last_grant 1 (requester 0 wins the first contention).
- Reset mid-operation: asserting rst_n low clears all registers immediately. The in-flight result is discarded and no out_valid pulse appears.

## Timing
- Handshake on edge N → out_valid high after edge N+3.
- out_ready tied high → out_valid is high for exactly one cycle and the FSM is back in IDLE after edge N+4.
- Earliest next accept is edge N+5. Maximum throughput is 1 result per 5 cycles.
- Backpressure: out_valid stays high indefinitely while out_ready is low. The FSM stays in DONE and both in_ready are 0.
- in_ready is combinational from in_valid and state. There is no combinational path from out_ready to any in_ready.
- Simultaneous valids: exactly one is granted. The loser's ready stays low, and that requester is granted at the next IDLE if still valid.

## Configuration
- MODE2_SCHED_FIXPRI_EN defined: fixed priority.
  - Requester 0 always wins contention.
  - last_grant is not implemented; requester 1 can starve.
- Undefined (default): round-robin as specified above.

## Test plan
- Req0 only, a=3, b=5, out_ready=1 → out_valid after edge N+3, out_data=256, out_id=0; busy 1 from edge N to edge N+4.
- Req1 only, a=7, b=0, then a=0, b=7 → 2401 both times, out_id=1; the second accept occurs no earlier than 5 cycles after the first.
- Both valid from reset, req0 (2,2), req1 (7,7), held → first result 0 with id 0, second 0 with id 1.
  - With MODE2_SCHED_FIXPRI_EN and req0 re-asserting a new pair immediately, req0 is granted twice in a row.
- out_ready low for 10 cycles after out_valid (a=5, b=3) → out_data=256 held stable, both in_ready 0; one handshake on out_ready, then IDLE.
- rst_n pulsed low during SQ_B → all outputs 0 asynchronously, no result emitted; after release, a new request (1,0) yields out_data=1.
- Exhaustive 64 pairs × both requesters vs. golden model (a²−b²)² → all match, ids correct.

Source files
------------

// File: rtl/mode2_sched_if.sv
// mode2_sched_if: request/result bundle for the mode-2 sequencer.
// Two valid/ready request channels (requester 0 and 1) and one tagged
// valid/ready result channel. The master drives requests and consumes results.
interface mode2_sched_if;
   logic        in_valid0;
   logic [2:0]  in_a0;
   logic [2:0]  in_b0;
   logic        in_ready0;
   logic        in_valid1;
   logic [2:0]  in_a1;
   logic [2:0]  in_b1;
   logic        in_ready1;
   logic        out_valid;
   logic [11:0] out_data;
   logic        out_id;
   logic        out_ready;

   modport master (
      output in_valid0, in_a0, in_b0, in_valid1, in_a1, in_b1, out_ready,
      input  in_ready0, in_ready1, out_valid, out_data, out_id
   );

   modport slave (
      input  in_valid0, in_a0, in_b0, in_valid1, in_a1, in_b1, out_ready,
      output in_ready0, in_ready1, out_valid, out_data, out_id
   );
endinterface

// File: rtl/mode2_sched.sv
// mode2_sched: computes (a^2 - b^2)^2 on 3-bit operands for two requesters
// using one time-multiplexed 7-bit squarer.
// Sequence: IDLE -> SQ_A -> SQ_B -> SQ_D -> DONE -> IDLE.
// Define MODE2_SCHED_FIXPRI_EN for fixed priority (requester 0 always wins
// contention, no last_grant state); default is round-robin arbitration.
module mode2_sched (
   input  logic          clk,
   input  logic          rst_n,
   mode2_sched_if.slave  bus,
   output logic          busy
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] SQ_A = 3'd1;
   localparam logic [2:0] SQ_B = 3'd2;
   localparam logic [2:0] SQ_D = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   logic [2:0]  state;
   logic [2:0]  a_q;
   logic [2:0]  b_q;
   logic        id_q;
   logic [5:0]  a2_q;
   logic [5:0]  absdiff_q;
   logic        out_valid_q;
   logic [11:0] out_data_q;
   logic        out_id_q;

   logic        grant;
   logic        accept;
   logic [6:0]  sq_in;
   logic [11:0] sq_out;
   logic [6:0]  diff;
   logic [6:0]  neg_diff;
   logic [5:0]  absdiff;

`ifndef MODE2_SCHED_FIXPRI_EN
   logic        last_grant;
`endif

   // Grant selection: a lone valid wins; on contention the arbitration policy decides.
   always_comb begin
      grant = 1'b0;
`ifdef MODE2_SCHED_FIXPRI_EN
      grant = !bus.in_valid0;
`else
      if (bus.in_valid0 && bus.in_valid1)
         grant = ~last_grant;
      else
         grant = !bus.in_valid0;
`endif
   end

   assign bus.in_ready0 = (state == IDLE) && bus.in_valid0 && !grant;
   assign bus.in_ready1 = (state == IDLE) && bus.in_valid1 && grant;
   assign accept        = (state == IDLE) && (bus.in_valid0 || bus.in_valid1);

   // Squarer operand mux: one shared multiplier serves a, b and |a^2 - b^2| in turn.
   always_comb begin
      sq_in = 7'd0;
      case (state)
         SQ_A:    sq_in = {4'b0, a_q};
         SQ_B:    sq_in = {4'b0, b_q};
         SQ_D:    sq_in = {1'b0, absdiff_q};
         default: sq_in = 7'd0;
      endcase
   end

   // Shared squarer; 49^2 = 2401 fits in 12 bits so the narrow product is exact.
   assign sq_out = {5'b0, sq_in} * {5'b0, sq_in};

   // Magnitude of a^2 - b^2 while b^2 is on the squarer output.
   always_comb begin
      diff     = {1'b0, a2_q} - {1'b0, sq_out[5:0]};
      neg_diff = 7'd0 - diff;
      absdiff  = diff[6] ? neg_diff[5:0] : diff[5:0];
   end

   // Main sequencer: capture, three squarer passes, then hold the result until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_q         <= 3'd0;
         b_q         <= 3'd0;
         id_q        <= 1'b0;
         a2_q        <= 6'd0;
         absdiff_q   <= 6'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 12'd0;
         out_id_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q   <= grant ? bus.in_a1 : bus.in_a0;
                  b_q   <= grant ? bus.in_b1 : bus.in_b0;
                  id_q  <= grant;
                  state <= SQ_A;
               end
            end
            SQ_A: begin
               a2_q  <= sq_out[5:0];
               state <= SQ_B;
            end
            SQ_B: begin
               absdiff_q <= absdiff;
               state     <= SQ_D;
            end
            SQ_D: begin
               out_data_q  <= sq_out;
               out_id_q    <= id_q;
               out_valid_q <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (out_valid_q && bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef MODE2_SCHED_FIXPRI_EN
   // Remember the last winner so contention alternates; starts at 1 so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= 1'b1;
      else if (accept)
         last_grant <= grant;
   end
`endif

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mode2_sched.sv
// tb_mode2_sched: self-checking bench for mode2_sched with a behavioural
// model of (a^2 - b^2)^2 and of the arbitration rules.
module tb_mode2_sched;

   logic clk;
   logic rst_n;
   logic busy;
   int   checks;
   int   failures;
   int   cyc;
   int   hs_cyc;

   mode2_sched_if bus_if ();

   mode2_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to measure spacing between accepts.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] golden(input int a, input int b);
      int d;
      d = a * a - b * b;
      return 12'(d * d);
   endfunction

   // Present one request, wait for its ready, complete the handshake and drop valid.
   task automatic send(input bit id, input logic [2:0] a, input logic [2:0] b, output int waited);
      waited = -1;
      if (id == 1'b0) begin
         bus_if.in_valid0 = 1'b1; bus_if.in_a0 = a; bus_if.in_b0 = b;
      end else begin
         bus_if.in_valid1 = 1'b1; bus_if.in_a1 = a; bus_if.in_b1 = b;
      end
      for (int i = 0; i < 20; i++) begin
         #1;
         if ((id == 1'b0 && bus_if.in_ready0) || (id == 1'b1 && bus_if.in_ready1)) begin
            waited = i;
            break;
         end
         @(negedge clk);
      end
      hs_cyc = cyc;
      @(posedge clk);
      @(negedge clk);
      if (id == 1'b0) bus_if.in_valid0 = 1'b0;
      else            bus_if.in_valid1 = 1'b0;
   endtask

   // Wait (bounded) for out_valid, starting at the negedge after the accept edge.
   task automatic collect(output logic [11:0] d, output logic i, output int lat);
      lat = -1;
      d   = 12'd0;
      i   = 1'b0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (bus_if.out_valid) begin
            d = bus_if.out_data;
            i = bus_if.out_id;
            lat = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus_if.in_valid0 = 1'b0; bus_if.in_a0 = 3'd0; bus_if.in_b0 = 3'd0;
      bus_if.in_valid1 = 1'b0; bus_if.in_a1 = 3'd0; bus_if.in_b1 = 3'd0;
      bus_if.out_ready = 1'b1;
      #22;
      checks++;
      if (bus_if.out_valid !== 1'b0 || bus_if.out_data !== 12'd0 || bus_if.out_id !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: valid=%b data=%0d id=%b busy=%b, required 0 0 0 0",
                  bus_if.out_valid, bus_if.out_data, bus_if.out_id, busy);
      end
      checks++;
      if (bus_if.in_ready0 !== 1'b0 || bus_if.in_ready1 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_ready: ready0=%b ready1=%b, required 0 0", bus_if.in_ready0, bus_if.in_ready1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_contention();
      logic [11:0] d;
      logic i;
      int lat;
      bus_if.in_valid0 = 1'b1; bus_if.in_a0 = 3'd2; bus_if.in_b0 = 3'd2;
      bus_if.in_valid1 = 1'b1; bus_if.in_a1 = 3'd7; bus_if.in_b1 = 3'd7;
      #1;
      checks++;
      if (bus_if.in_ready0 !== 1'b1 || bus_if.in_ready1 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL contention_first_grant: ready0=%b ready1=%b, required 1 0", bus_if.in_ready0, bus_if.in_ready1);
      end
      @(posedge clk);
      @(negedge clk);
`ifdef MODE2_SCHED_FIXPRI_EN
      bus_if.in_a0 = 3'd3; bus_if.in_b0 = 3'd1;
`else
      bus_if.in_valid0 = 1'b0;
`endif
      collect(d, i, lat);
      checks++;
      if (lat != 3 || d !== 12'd0 || i !== 1'b0) begin
         failures++;
         $display("[TB] FAIL contention_first_result: lat=%0d data=%0d id=%b, required 3 0 0", lat, d, i);
      end
      @(negedge clk);
      #1;
`ifdef MODE2_SCHED_FIXPRI_EN
      checks++;
      if (bus_if.in_ready0 !== 1'b1 || bus_if.in_ready1 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL fixpri_regrant: ready0=%b ready1=%b, required 1 0", bus_if.in_ready0, bus_if.in_ready1);
      end
      @(posedge clk);
      @(negedge clk);
      bus_if.in_valid0 = 1'b0;
      collect(d, i, lat);
      checks++;
      if (d !== 12'd64 || i !== 1'b0) begin
         failures++;
         $display("[TB] FAIL fixpri_second_result: data=%0d id=%b, required 64 0", d, i);
      end
      @(negedge clk);
      #1;
`endif
      checks++;
      if (bus_if.in_ready1 !== 1'b1 || bus_if.in_ready0 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL contention_loser_grant: ready0=%b ready1=%b, required 0 1", bus_if.in_ready0, bus_if.in_ready1);
      end
      @(posedge clk);
      @(negedge clk);
      bus_if.in_valid1 = 1'b0;
      collect(d, i, lat);
      checks++;
      if (d !== 12'd0 || i !== 1'b1) begin
         failures++;
         $display("[TB] FAIL contention_second_result: data=%0d id=%b, required 0 1", d, i);
      end
      @(negedge clk);
   endtask

   task automatic test_req0_single();
      int waited;
      int first_valid;
      int valid_count;
      logic [11:0] d;
      first_valid = -1;
      valid_count = 0;
      d = 12'd0;
      bus_if.out_ready = 1'b1;
      send(1'b0, 3'd3, 3'd5, waited);
      for (int k = 0; k < 6; k++) begin
         #1;
         if (bus_if.out_valid) begin
            valid_count++;
            if (first_valid < 0) begin
               first_valid = k;
               d = bus_if.out_data;
            end
         end
         checks++;
         if (busy !== (k <= 3)) begin
            failures++;
            $display("[TB] FAIL req0_busy_k%0d: busy=%b, required %b", k, busy, (k <= 3));
         end
         @(negedge clk);
      end
      checks++;
      if (waited != 0 || first_valid != 3 || valid_count != 1) begin
         failures++;
         $display("[TB] FAIL req0_timing: waited=%0d first_valid=%0d count=%0d, required 0 3 1", waited, first_valid, valid_count);
      end
      checks++;
      if (d !== 12'd256) begin
         failures++;
         $display("[TB] FAIL req0_data: data=%0d, required 256", d);
      end
   endtask

   task automatic test_back_to_back();
      int waited;
      int t1;
      int lat;
      logic [11:0] d;
      logic i;
      send(1'b1, 3'd7, 3'd0, waited);
      t1 = hs_cyc;
      collect(d, i, lat);
      checks++;
      if (d !== 12'd2401 || i !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_first: data=%0d id=%b, required 2401 1", d, i);
      end
      @(negedge clk);
      send(1'b1, 3'd0, 3'd7, waited);
      checks++;
      if (waited < 0 || hs_cyc - t1 < 5) begin
         failures++;
         $display("[TB] FAIL b2b_spacing: waited=%0d spacing=%0d, required >=0 and >=5", waited, hs_cyc - t1);
      end
      collect(d, i, lat);
      checks++;
      if (d !== 12'd2401 || i !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_second: data=%0d id=%b, required 2401 1", d, i);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int waited;
      int lat;
      logic [11:0] d;
      logic i;
      bus_if.out_ready = 1'b0;
      send(1'b0, 3'd5, 3'd3, waited);
      collect(d, i, lat);
      checks++;
      if (lat != 3 || d !== 12'd256 || i !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bp_result: lat=%0d data=%0d id=%b, required 3 256 0", lat, d, i);
      end
      bus_if.in_valid1 = 1'b1; bus_if.in_a1 = 3'd1; bus_if.in_b1 = 3'd1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 12'd256 || bus_if.out_id !== 1'b0 ||
             bus_if.in_ready0 !== 1'b0 || bus_if.in_ready1 !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_hold_k%0d: valid=%b data=%0d id=%b r0=%b r1=%b busy=%b, required 1 256 0 0 0 1",
                     k, bus_if.out_valid, bus_if.out_data, bus_if.out_id, bus_if.in_ready0, bus_if.in_ready1, busy);
         end
      end
      bus_if.in_valid1 = 1'b0;
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (bus_if.out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bp_release: valid=%b busy=%b, required 0 0", bus_if.out_valid, busy);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int waited;
      int lat;
      int seen;
      logic [11:0] d;
      logic i;
      send(1'b1, 3'd6, 3'd2, waited);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus_if.out_valid !== 1'b0 || bus_if.out_data !== 12'd0 || bus_if.out_id !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midreset_clear: valid=%b data=%0d id=%b busy=%b, required 0 0 0 0",
                  bus_if.out_valid, bus_if.out_data, bus_if.out_id, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         #1;
         if (bus_if.out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("[TB] FAIL midreset_no_result: out_valid cycles=%0d, required 0", seen);
      end
      @(negedge clk);
      send(1'b0, 3'd1, 3'd0, waited);
      collect(d, i, lat);
      checks++;
      if (lat != 3 || d !== 12'd1 || i !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midreset_after: lat=%0d data=%0d id=%b, required 3 1 0", lat, d, i);
      end
      @(negedge clk);
   endtask

   task automatic test_exhaustive();
      int waited;
      int lat;
      logic [11:0] d;
      logic i;
      bus_if.out_ready = 1'b1;
      for (int id = 0; id < 2; id++) begin
         for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
               send(id[0], a[2:0], b[2:0], waited);
               collect(d, i, lat);
               checks++;
               if (waited < 0 || lat < 0 || d !== golden(a, b) || i !== id[0]) begin
                  failures++;
                  $display("[TB] FAIL exh_id%0d_a%0d_b%0d: waited=%0d lat=%0d data=%0d id=%b, required data=%0d id=%0d",
                           id, a, b, waited, lat, d, i, golden(a, b), id);
               end
               @(negedge clk);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [11:0] exp_d[$];
      logic        exp_i[$];
      logic        last_model;
      bit          known;
      bit          hs0, hs1;
      logic        k;
      logic        exp_k;
      logic [11:0] ed;
      logic        ei;
      known = 1'b0;
      last_model = 1'b0;
      bus_if.in_valid0 = 1'b0;
      bus_if.in_valid1 = 1'b0;
      for (int n = 0; n < 800; n++) begin
         #1;
         if (bus_if.in_ready0 && bus_if.in_ready1) begin
            checks++;
            failures++;
            $display("[TB] FAIL rand_dual_ready: cycle %0d both readies high, required at most one", n);
         end
         hs0 = bus_if.in_valid0 && bus_if.in_ready0;
         hs1 = bus_if.in_valid1 && bus_if.in_ready1;
         if (hs0 || hs1) begin
            k = hs1;
            if (bus_if.in_valid0 && bus_if.in_valid1) begin
`ifdef MODE2_SCHED_FIXPRI_EN
               exp_k = 1'b0;
`else
               exp_k = ~last_model;
`endif
               if (known) begin
                  checks++;
                  if (k !== exp_k) begin
                     failures++;
                     $display("[TB] FAIL rand_arbitration: granted=%b, required %b", k, exp_k);
                  end
               end
            end
            last_model = k;
            known = 1'b1;
            if (k) begin
               exp_d.push_back(golden(int'(bus_if.in_a1), int'(bus_if.in_b1)));
            end else begin
               exp_d.push_back(golden(int'(bus_if.in_a0), int'(bus_if.in_b0)));
            end
            exp_i.push_back(k);
         end
         if (bus_if.out_valid && bus_if.out_ready) begin
            checks++;
            if (exp_d.size() == 0) begin
               failures++;
               $display("[TB] FAIL rand_unexpected: data=%0d id=%b, required no result", bus_if.out_data, bus_if.out_id);
            end else begin
               ed = exp_d.pop_front();
               ei = exp_i.pop_front();
               if (bus_if.out_data !== ed || bus_if.out_id !== ei) begin
                  failures++;
                  $display("[TB] FAIL rand_result: data=%0d id=%b, required %0d %b", bus_if.out_data, bus_if.out_id, ed, ei);
               end
            end
         end
         @(negedge clk);
         if (hs0) bus_if.in_valid0 = 1'b0;
         if (hs1) bus_if.in_valid1 = 1'b0;
         if (!bus_if.in_valid0 && ($urandom % 2 == 0)) begin
            bus_if.in_valid0 = 1'b1;
            bus_if.in_a0 = 3'($urandom_range(0, 7));
            bus_if.in_b0 = 3'($urandom_range(0, 7));
         end
         if (!bus_if.in_valid1 && ($urandom % 2 == 0)) begin
            bus_if.in_valid1 = 1'b1;
            bus_if.in_a1 = 3'($urandom_range(0, 7));
            bus_if.in_b1 = 3'($urandom_range(0, 7));
         end
         bus_if.out_ready = ($urandom % 4 != 0);
      end
      bus_if.in_valid0 = 1'b0;
      bus_if.in_valid1 = 1'b0;
      bus_if.out_ready = 1'b1;
      for (int n = 0; n < 20; n++) begin
         #1;
         if (bus_if.out_valid && exp_d.size() != 0) begin
            ed = exp_d.pop_front();
            ei = exp_i.pop_front();
            checks++;
            if (bus_if.out_data !== ed || bus_if.out_id !== ei) begin
               failures++;
               $display("[TB] FAIL rand_drain: data=%0d id=%b, required %0d %b", bus_if.out_data, bus_if.out_id, ed, ei);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (exp_d.size() != 0) begin
         failures++;
         $display("[TB] FAIL rand_lost: %0d results outstanding, required 0", exp_d.size());
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      checks   = 0;
      failures = 0;
      hs_cyc   = 0;
      test_reset();
      test_contention();
      test_req0_single();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_exhaustive();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
